// File: rtl/multi_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multi_accum_pkg
//  Description : Shared types for the multi-channel accumulator. Holds the
//                command opcode encoding and the sweep FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package multi_accum_pkg;

  // Command opcodes as they appear on the in_op pins
  typedef enum logic [1:0] {
    OP_ADD       = 2'b00,
    OP_SUB       = 2'b01,
    OP_LOAD      = 2'b10,
    OP_CLEAR_ALL = 2'b11
  } op_e;

  // Control FSM: normal command processing or clear-all sweep
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

endpackage : multi_accum_pkg
`default_nettype wire

// File: rtl/accum_alu.sv
`default_nettype none
// ============================================================================
//  Module      : accum_alu
//  Description : Combinational accumulator update. Produces the next
//                accumulator value for one command and a carry/borrow flag.
//                Build option MULTI_ACCUM_SAT_EN: when defined, ADD clamps to
//                all-ones on carry and SUB clamps to zero on borrow; when
//                undefined, results wrap modulo 2^ACC_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module accum_alu
  import multi_accum_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] operand,
  input  op_e              op,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  logic [ACC_W:0] ext;

  // One extra bit on the arithmetic exposes carry-out (ADD) or borrow (SUB)
  always_comb begin
    ext    = '0;
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        ext = {1'b0, acc} + {1'b0, operand};
        ovf = ext[ACC_W];
`ifdef MULTI_ACCUM_SAT_EN
        result = ovf ? '1 : ext[ACC_W-1:0];
`else
        result = ext[ACC_W-1:0];
`endif
      end
      OP_SUB: begin
        ext = {1'b0, acc} - {1'b0, operand};
        ovf = ext[ACC_W];
`ifdef MULTI_ACCUM_SAT_EN
        result = ovf ? '0 : ext[ACC_W-1:0];
`else
        result = ext[ACC_W-1:0];
`endif
      end
      OP_LOAD: result = operand;
      default: result = '0;
    endcase
  end

endmodule : accum_alu
`default_nettype wire

// File: rtl/multi_accum.sv
`default_nettype none
// ============================================================================
//  Module      : multi_accum
//  Description : CHANNELS independent ACC_W-bit accumulators driven by a
//                valid/ready command stream (ADD/SUB/LOAD/CLEAR_ALL), with a
//                registered write-through read port and sticky per-channel
//                overflow flags. Two-stage pipeline: accept into S1, write the
//                array from S1 on the next edge.
//                Build option MULTI_ACCUM_SAT_EN selects saturating ADD/SUB
//                (handled inside accum_alu).
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_accum
  import multi_accum_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int ACC_W    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(CHANNELS)-1:0]   in_ch,
  input  logic [1:0]                    in_op,
  input  logic [IN_W-1:0]               in_data,
  input  logic                          rd_en,
  input  logic [$clog2(CHANNELS)-1:0]   rd_ch,
  output logic                          rd_valid,
  output logic [ACC_W-1:0]              rd_data,
  output logic [CHANNELS-1:0]           ovf,
  input  logic                          ovf_clr
);

  localparam int CH_W = $clog2(CHANNELS);

  generate
    if (ACC_W < IN_W || CHANNELS < 2 || (CHANNELS & (CHANNELS - 1)) != 0) begin : g_param_check
      $error("multi_accum: need ACC_W >= IN_W and CHANNELS a power of 2 >= 2");
    end
  endgenerate

  // S1 command register; widths follow this instance's parameters
  typedef struct packed {
    logic            valid;
    op_e             op;
    logic [CH_W-1:0] ch;
    logic [IN_W-1:0] data;
  } s1_t;

  s1_t                 s1_q, s1_d;
  logic [ACC_W-1:0]    acc_q [CHANNELS];
  logic [ACC_W-1:0]    acc_d [CHANNELS];
  state_e              state_q, state_d;
  logic [CH_W-1:0]     sweep_idx_q, sweep_idx_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic                rd_valid_q, rd_valid_d;
  logic [ACC_W-1:0]    rd_data_q, rd_data_d;

  logic                s1_is_clear;
  logic [ACC_W-1:0]    alu_res;
  logic                alu_ovf;
  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [ACC_W-1:0]    wr_val;

  assign s1_is_clear = s1_q.valid && (s1_q.op == OP_CLEAR_ALL);

  // Ready drops as soon as a CLEAR_ALL sits in S1 so nothing can queue behind it
  assign in_ready = ~rst && (state_q == ST_IDLE) && ~s1_is_clear;

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign ovf      = ovf_q;

  accum_alu #(
    .ACC_W (ACC_W)
  ) u_alu (
    .acc     (acc_q[s1_q.ch]),
    .operand (ACC_W'(s1_q.data)),
    .op      (s1_q.op),
    .result  (alu_res),
    .ovf     (alu_ovf)
  );

  // Single array write port: the sweep owns it in SWEEP, otherwise S2.
  // A CLEAR_ALL in S2 clears channel 0 itself; the sweep then covers the rest.
  always_comb begin
    wr_en  = 1'b0;
    wr_ch  = '0;
    wr_val = '0;
    if (state_q == ST_SWEEP) begin
      wr_en = 1'b1;
      wr_ch = sweep_idx_q;
    end else if (s1_q.valid) begin
      wr_en  = 1'b1;
      wr_ch  = s1_is_clear ? '0 : s1_q.ch;
      wr_val = alu_res;
    end
  end

  // Sweep FSM next state and channel index
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (s1_is_clear) begin
          state_d     = ST_SWEEP;
          sweep_idx_d = CH_W'(1);
        end
      end
      ST_SWEEP: begin
        if (sweep_idx_q == CH_W'(CHANNELS - 1)) begin
          state_d     = ST_IDLE;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        sweep_idx_d = '0;
      end
    endcase
  end

  // Array, flags, S1 capture and write-through read port
  always_comb begin
    acc_d = acc_q;
    if (wr_en) begin
      acc_d[wr_ch] = wr_val;
    end

    // A flag being set in the same cycle as ovf_clr stays set
    ovf_d = ovf_clr ? '0 : ovf_q;
    if ((state_q == ST_IDLE) && s1_q.valid && alu_ovf) begin
      ovf_d[s1_q.ch] = 1'b1;
    end

    s1_d.valid = in_valid && in_ready;
    s1_d.op    = op_e'(in_op);
    s1_d.ch    = in_ch;
    s1_d.data  = in_data;

    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      rd_data_d = (wr_en && (wr_ch == rd_ch)) ? wr_val : acc_q[rd_ch];
    end
  end

  // All state registers; reset discards any in-flight command or sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      state_q     <= ST_IDLE;
      sweep_idx_q <= '0;
      ovf_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      s1_q        <= s1_d;
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      ovf_q       <= ovf_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

endmodule : multi_accum
`default_nettype wire

// File: tb/tb_multi_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_accum
//  Description : Directed self-checking bench for multi_accum (IN_W=8,
//                ACC_W=16, CHANNELS=4). Expected values follow the
//                MULTI_ACCUM_SAT_EN build option when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_accum;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] LDV = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_ch = '0;
  logic [1:0]  in_op = '0;
  logic [7:0]  in_data = '0;
  logic        rd_en = 1'b0;
  logic [1:0]  rd_ch = '0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [3:0]  ovf;
  logic        ovf_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  multi_accum #(
    .IN_W     (8),
    .ACC_W    (16),
    .CHANNELS (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ch    (in_ch),
    .in_op    (in_op),
    .in_data  (in_data),
    .rd_en    (rd_en),
    .rd_ch    (rd_ch),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until accepted (bounded)
  task automatic send(input logic [1:0] op, input logic [1:0] ch, input logic [7:0] data);
    bit done = 0;
    in_valid = 1'b1; in_op = op; in_ch = ch; in_data = data;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_accept: command op=%0d ch=%0d never accepted (ready=%b, required 1)", op, ch, in_ready);
    end
  endtask

  task automatic rd(input logic [1:0] ch, output logic [15:0] data, output logic valid);
    rd_en = 1'b1; rd_ch = ch;
    step();
    rd_en = 1'b0;
    data = rd_data; valid = rd_valid;
  endtask

  task automatic test_reset();
    logic [15:0] d; logic v;
    rst = 1'b1;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", in_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL reset_ovf: got %b want 0000", ovf); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b want 1", in_ready); end
    for (int c = 0; c < 4; c++) begin
      rd(2'(c), d, v);
      checks++;
      if (d !== 16'h0000 || v !== 1'b1) begin
        errors++; $display("FAIL reset_acc%0d: got %h valid %b want 0000 valid 1", c, d, v);
      end
    end
  endtask

  task automatic test_add();
    logic [15:0] d; logic v;
    send(ADD, 2'd1, 8'h05);
    send(ADD, 2'd1, 8'h05);
    send(ADD, 2'd1, 8'h05);
    rd(2'd1, d, v);
    checks++; if (d !== 16'h000F) begin errors++; $display("FAIL add_ch1: got %h want 000f", d); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL add_rd_valid: got %b want 1", v); end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL add_ovf: got %b want 0000", ovf); end
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL idle_rd_valid: got %b want 0", rd_valid); end
  endtask

  task automatic test_wrap();
    logic [15:0] d; logic v; logic [15:0] exp;
`ifdef MULTI_ACCUM_SAT_EN
    exp = 16'hFFFF;
`else
    exp = 16'((255 * 258) % 65536);
`endif
    send(LDV, 2'd2, 8'hFF);
    for (int i = 0; i < 257; i++) send(ADD, 2'd2, 8'hFF);
    rd(2'd2, d, v);
    checks++; if (d !== exp) begin errors++; $display("FAIL wrap_ch2: got %h want %h", d, exp); end
    checks++; if (ovf !== 4'b0100) begin errors++; $display("FAIL wrap_ovf: got %b want 0100", ovf); end
  endtask

  task automatic test_sub();
    logic [15:0] d; logic v; logic [15:0] exp;
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL ovf_clr_1: got %b want 0000", ovf); end
`ifdef MULTI_ACCUM_SAT_EN
    exp = 16'h0000;
`else
    exp = 16'hFFFF;
`endif
    send(SUB, 2'd0, 8'h01);
    rd(2'd0, d, v);
    checks++; if (d !== exp) begin errors++; $display("FAIL sub_ch0: got %h want %h", d, exp); end
    checks++; if (ovf !== 4'b0001) begin errors++; $display("FAIL sub_ovf: got %b want 0001", ovf); end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL ovf_clr_2: got %b want 0000", ovf); end
    // ch1 holds 0x000F: subtracting 0x10 borrows on the same edge ovf_clr is high
    send(SUB, 2'd1, 8'h10);
    ovf_clr = 1'b1; rd_en = 1'b1; rd_ch = 2'd1;
    step();
    ovf_clr = 1'b0; rd_en = 1'b0;
    checks++; if (ovf !== 4'b0010) begin errors++; $display("FAIL set_wins: got %b want 0010", ovf); end
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL sub_ch1: got %h want %h", rd_data, exp); end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
  endtask

  task automatic test_bypass();
    logic [15:0] d; logic v;
    send(LDV, 2'd3, 8'h42);
    rd(2'd3, d, v);
    checks++; if (d !== 16'h0042 || v !== 1'b1) begin errors++; $display("FAIL bypass_ch3: got %h valid %b want 0042 valid 1", d, v); end
  endtask

  task automatic test_clear_all();
    logic [15:0] d; logic v; int low;
    send(LDV, 2'd0, 8'h11);
    send(LDV, 2'd1, 8'h22);
    send(LDV, 2'd2, 8'h33);
    send(LDV, 2'd3, 8'h44);
    send(SUB, 2'd3, 8'h50);
    step();
    checks++; if (ovf !== 4'b1000) begin errors++; $display("FAIL pre_clear_ovf: got %b want 1000", ovf); end
    send(CLR, 2'd2, 8'hAA);
    // hold the next command while the sweep runs
    in_valid = 1'b1; in_op = ADD; in_ch = 2'd2; in_data = 8'h07;
    low = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) break;
      low++;
      rd_en = (i < 4); rd_ch = 2'(i);
      step();
      if (i < 4) begin
        checks++;
        if (rd_data !== 16'h0000 || rd_valid !== 1'b1) begin
          errors++; $display("FAIL sweep_read_ch%0d: got %h valid %b want 0000 valid 1", i, rd_data, rd_valid);
        end
      end
    end
    rd_en = 1'b0;
    checks++; if (low !== 4) begin errors++; $display("FAIL clear_ready_low: got %0d cycles want 4", low); end
    step();
    in_valid = 1'b0;
    rd(2'd2, d, v);
    checks++; if (d !== 16'h0007) begin errors++; $display("FAIL held_cmd_ch2: got %h want 0007", d); end
    checks++; if (ovf !== 4'b1000) begin errors++; $display("FAIL clear_keeps_ovf: got %b want 1000", ovf); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] d; logic v;
    send(LDV, 2'd1, 8'h55);
    send(LDV, 2'd3, 8'h66);
    send(CLR, 2'd0, 8'h00);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_sweep_ready: got %b want 1", in_ready); end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL abort_ovf: got %b want 0000", ovf); end
    for (int c = 0; c < 4; c++) begin
      rd(2'(c), d, v);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL abort_sweep_acc%0d: got %h want 0000", c, d); end
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_sweep_idle: got %b want 1", in_ready); end
    // reset with an ADD waiting in S1: it must not land afterwards
    send(ADD, 2'd2, 8'h09);
    rst = 1'b1; step(); rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_s1_ready: got %b want 1", in_ready); end
    step(); step();
    rd(2'd2, d, v);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL abort_s1_stale: got %h want 0000", d); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_wrap();
    test_sub();
    test_bypass();
    test_clear_all();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_multi_accum
`default_nettype wire
